// File: rtl/tq_dequant_4x4_if.sv
// Row-in / block-out handshake bundle for the 4x4 inverse quantiser.
interface tq_dequant_4x4_if #(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 15
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            in_qp;
    logic [4*COEF_W-1:0]   in_row;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*OUT_W-1:0]   out_blk;
    logic                  out_nz;

    modport master (
        output in_valid, in_qp, in_row, out_ready,
        input  in_ready, out_valid, out_blk, out_nz
    );

    modport slave (
        input  in_valid, in_qp, in_row, out_ready,
        output in_ready, out_valid, out_blk, out_nz
    );
endinterface

// File: rtl/tq_dequant_4x4.sv
// H.264 flat-scaling inverse quantiser: rescales one row of levels per beat and
// buffers a full saturated 4x4 block for the inverse core transform.
module tq_dequant_lane #(
    parameter int COEF_W  = 12,
    parameter int OUT_W   = 15,
    parameter bit COL_ODD = 1'b0
) (
    input  logic signed [COEF_W-1:0] lvl_i,
    input  logic                     row_odd_i,
    input  logic [3:0]               qp_div_i,
    input  logic [2:0]               qp_mod_i,
    output logic signed [OUT_W-1:0]  coef_o,
    output logic                     nz_o
);
    // Wide enough for level * 29 << 8 plus sign, so nothing wraps before saturation.
    localparam int P_W = COEF_W + 14;
    localparam logic signed [P_W-1:0] MAX_V = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] MIN_V = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [4:0]            scale;
    logic signed [P_W-1:0] lvl_x;
    logic signed [P_W-1:0] scale_x;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;

    always_comb begin
        scale = 5'd0;
        if (row_odd_i != COL_ODD) begin
            case (qp_mod_i)
                3'd0: scale = 5'd13;
                3'd1: scale = 5'd14;
                3'd2: scale = 5'd16;
                3'd3: scale = 5'd18;
                3'd4: scale = 5'd20;
                3'd5: scale = 5'd23;
                default: scale = 5'd0;
            endcase
        end else if (row_odd_i) begin
            case (qp_mod_i)
                3'd0: scale = 5'd16;
                3'd1: scale = 5'd18;
                3'd2: scale = 5'd20;
                3'd3: scale = 5'd23;
                3'd4: scale = 5'd25;
                3'd5: scale = 5'd29;
                default: scale = 5'd0;
            endcase
        end else begin
            case (qp_mod_i)
                3'd0: scale = 5'd10;
                3'd1: scale = 5'd11;
                3'd2: scale = 5'd13;
                3'd3: scale = 5'd14;
                3'd4: scale = 5'd16;
                3'd5: scale = 5'd18;
                default: scale = 5'd0;
            endcase
        end
    end

    assign lvl_x   = P_W'(lvl_i);
    assign scale_x = {{(P_W-5){1'b0}}, scale};
    assign prod    = lvl_x * scale_x;
    assign shifted = prod <<< qp_div_i;

    always_comb begin
        if (shifted > MAX_V)      coef_o = MAX_V[OUT_W-1:0];
        else if (shifted < MIN_V) coef_o = MIN_V[OUT_W-1:0];
        else                      coef_o = shifted[OUT_W-1:0];
    end

    assign nz_o = (coef_o != '0);
endmodule

module tq_dequant_4x4 #(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 15
) (
    input logic              clk,
    input logic              rst,
    tq_dequant_4x4_if.slave  bus
);
    typedef enum logic {ST_COLLECT, ST_OUTPUT} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               row_cnt_q, row_cnt_d;
    logic [3:0]               qp_div_q, qp_div_d;
    logic [2:0]               qp_mod_q, qp_mod_d;
    logic [15:0][OUT_W-1:0]   blk_q, blk_d;
    logic                     nz_q, nz_d;

    logic                     accept;
    logic [5:0]               qp_cl;
    logic [3:0]               row_div;
    logic [2:0]               row_mod;
    logic [3:0][COEF_W-1:0]   lvl;
    logic [3:0][OUT_W-1:0]    row_coef;
    logic [3:0]               row_nz;

    assign accept = bus.in_valid && (state_q == ST_COLLECT);
    assign qp_cl  = (bus.in_qp > 6'd51) ? 6'd51 : bus.in_qp;
    // Row 0 rescales with its own qp in the same beat that latches it.
    assign row_div = (row_cnt_q == 2'd0) ? 4'(qp_cl / 6'd6) : qp_div_q;
    assign row_mod = (row_cnt_q == 2'd0) ? 3'(qp_cl % 6'd6) : qp_mod_q;
    assign lvl     = bus.in_row;

    for (genvar j = 0; j < 4; j++) begin : g_lane
        tq_dequant_lane #(
            .COEF_W  (COEF_W),
            .OUT_W   (OUT_W),
            .COL_ODD (bit'(j % 2))
        ) u_lane (
            .lvl_i     (lvl[j]),
            .row_odd_i (row_cnt_q[0]),
            .qp_div_i  (row_div),
            .qp_mod_i  (row_mod),
            .coef_o    (row_coef[j]),
            .nz_o      (row_nz[j])
        );
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        qp_div_d  = qp_div_q;
        qp_mod_d  = qp_mod_q;
        blk_d     = blk_q;
        nz_d      = nz_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    for (int j = 0; j < 4; j++) blk_d[{row_cnt_q, 2'(j)}] = row_coef[j];
                    row_cnt_d = row_cnt_q + 2'd1;
                    if (row_cnt_q == 2'd0) begin
                        qp_div_d = row_div;
                        qp_mod_d = row_mod;
                        nz_d     = |row_nz;
                    end else begin
                        nz_d     = nz_q | (|row_nz);
                    end
                    if (row_cnt_q == 2'd3) state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            row_cnt_q <= 2'd0;
            qp_div_q  <= 4'd0;
            qp_mod_q  <= 3'd0;
            blk_q     <= '0;
            nz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            qp_div_q  <= qp_div_d;
            qp_mod_q  <= qp_mod_d;
            blk_q     <= blk_d;
            nz_q      <= nz_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_COLLECT);
    assign bus.out_valid = (state_q == ST_OUTPUT);
    assign bus.out_blk   = blk_q;
    assign bus.out_nz    = nz_q;
endmodule

// File: tb/tb_tq_dequant_4x4.sv
// Bench for tq_dequant_4x4: directed vector table, handshake corner cases and
// random blocks checked against an arithmetic reference model.
module tb_tq_dequant_4x4;
    localparam int COEF_W = 12;
    localparam int OUT_W  = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tq_dequant_4x4_if #(.COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();
    tq_dequant_4x4 #(.COEF_W(COEF_W), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int    lv[16];
        int    qp0;
        int    qpn;
        int    ex[16];
        bit    ex_nz;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: level * normAdjust(qp%6, class) * 2^(qp/6), clamped to 15-bit signed.
    function automatic int dq(int lv, int r, int c, int qp);
        int vA[6] = '{10, 11, 13, 14, 16, 18};
        int vB[6] = '{16, 18, 20, 23, 25, 29};
        int vC[6] = '{13, 14, 16, 18, 20, 23};
        int q = (qp > 51) ? 51 : qp;
        int v;
        longint p;
        if (r % 2 == 0 && c % 2 == 0)      v = vA[q % 6];
        else if (r % 2 == 1 && c % 2 == 1) v = vB[q % 6];
        else                               v = vC[q % 6];
        p = longint'(lv) * v * (longint'(1) << (q / 6));
        if (p > 16383)  p = 16383;
        if (p < -16384) p = -16384;
        return int'(p);
    endfunction

    function automatic int coef(int k);
        logic signed [OUT_W-1:0] s;
        s = bus.out_blk[k*OUT_W +: OUT_W];
        return int'(s);
    endfunction

    task automatic send_row(input int lv[16], input int r, input int qp, input string name);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_qp    = 6'(qp);
        for (int c = 0; c < 4; c++) bus.in_row[c*COEF_W +: COEF_W] = COEF_W'(lv[4*r+c]);
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk({name, " in_ready timeout"}, 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input int lv[16], input int qp0, input int qpn, input int gap,
                              input string name);
        for (int r = 0; r < 4; r++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            send_row(lv, r, (r == 0) ? qp0 : qpn, name);
        end
    endtask

    task automatic recv_block(input int ex[16], input bit ex_nz, input int bp, input string name);
        int n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk({name, " out_valid latency"}, n, 0);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s d%0d%0d", name, k / 4, k % 4), coef(k), ex[k]);
        chk({name, " out_nz"}, bus.out_nz, ex_nz);
        repeat (bp) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({name, " out_valid drop"}, bus.out_valid, 0);
        chk({name, " in_ready back"}, bus.in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*OUT_W-1:0] held;
        int lv[16];
        int ex[16];
        int qp0, qpn, bp;
        bit nz;

        bus.in_valid = 1'b0; bus.in_qp = '0; bus.in_row = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_nz", bus.out_nz, 0);
        chk("reset out_blk zero", (bus.out_blk == '0), 1);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 16; k++) begin tbl[i].lv[k] = 0; tbl[i].ex[k] = 0; end
            tbl[i].ex_nz = 1'b1;
        end
        tbl[0].name = "T1"; tbl[0].qp0 = 0; tbl[0].qpn = 0;
        tbl[0].lv[0] = 1; tbl[0].lv[1] = 1; tbl[0].lv[5] = 1;
        tbl[0].ex[0] = 10; tbl[0].ex[1] = 13; tbl[0].ex[5] = 16;
        tbl[1].name = "T2"; tbl[1].qp0 = 28; tbl[1].qpn = 28;
        tbl[1].lv[0] = 1; tbl[1].lv[5] = -3; tbl[1].ex[0] = 256; tbl[1].ex[5] = -1200;
        tbl[2].name = "T3"; tbl[2].qp0 = 51; tbl[2].qpn = 51;
        tbl[2].lv[5] = 2047; tbl[2].lv[10] = -2047; tbl[2].ex[5] = 16383; tbl[2].ex[10] = -16384;
        tbl[3] = tbl[2]; tbl[3].name = "T3qp60"; tbl[3].qp0 = 60; tbl[3].qpn = 9;
        tbl[4].name = "T5"; tbl[4].qp0 = 0; tbl[4].qpn = 40;
        tbl[4].lv[10] = 1; tbl[4].ex[10] = 10;
        tbl[5].name = "zero"; tbl[5].qp0 = 20; tbl[5].qpn = 33; tbl[5].ex_nz = 1'b0;
        tbl[6].name = "mixed"; tbl[6].qp0 = 12; tbl[6].qpn = 50;
        tbl[6].lv[0] = -2048; tbl[6].lv[2] = 7; tbl[6].lv[9] = 100; tbl[6].lv[15] = -5;
        tbl[6].ex[0] = -16384; tbl[6].ex[2] = 280; tbl[6].ex[9] = 5200; tbl[6].ex[15] = -320;

        foreach (tbl[i]) begin
            send_block(tbl[i].lv, tbl[i].qp0, tbl[i].qpn, 0, tbl[i].name);
            recv_block(tbl[i].ex, tbl[i].ex_nz, 0, tbl[i].name);
        end

        // Backpressure: junk rows offered while a block is held must not be taken.
        send_block(tbl[6].lv, tbl[6].qp0, tbl[6].qpn, 0, "T4");
        held = bus.out_blk;
        bus.in_valid = 1'b1; bus.in_row = '1; bus.in_qp = 6'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("T4 in_ready low %0d", i), bus.in_ready, 0);
            chk($sformatf("T4 out_valid held %0d", i), bus.out_valid, 1);
            chk($sformatf("T4 out_blk stable %0d", i), (bus.out_blk == held), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        chk("T4 out_valid drop", bus.out_valid, 0);
        chk("T4 in_ready next", bus.in_ready, 1);
        send_block(tbl[0].lv, tbl[0].qp0, tbl[0].qpn, 0, "T4after");
        recv_block(tbl[0].ex, 1'b1, 0, "T4after");

        // Reset with two rows buffered.
        send_row(tbl[6].lv, 0, 12, "T6");
        send_row(tbl[6].lv, 1, 12, "T6");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("T6 out_valid", bus.out_valid, 0);
        chk("T6 in_ready", bus.in_ready, 1);
        chk("T6 out_nz", bus.out_nz, 0);
        for (int r = 0; r < 3; r++) send_row(tbl[2].lv, r, 51, "T6");
        chk("T6 no early valid", bus.out_valid, 0);
        send_row(tbl[2].lv, 3, 51, "T6");
        chk("T6 valid after 4th", bus.out_valid, 1);
        recv_block(tbl[2].ex, 1'b1, 0, "T6");

        for (int b = 0; b < 30; b++) begin
            qp0 = $urandom_range(0, 63);
            qpn = $urandom_range(0, 63);
            nz  = 1'b0;
            for (int k = 0; k < 16; k++) begin
                case ($urandom_range(0, 2))
                    0: lv[k] = 0;
                    1: lv[k] = int'($urandom_range(0, 16)) - 8;
                    default: lv[k] = int'($urandom_range(0, 4095)) - 2048;
                endcase
                ex[k] = dq(lv[k], k / 4, k % 4, qp0);
                if (ex[k] != 0) nz = 1'b1;
            end
            bp = $urandom_range(0, 3);
            send_block(lv, qp0, qpn, 2, $sformatf("rnd%0d", b));
            recv_block(ex, nz, bp, $sformatf("rnd%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
